lamp_sequencer: RTL and testbench

//  Downstream stage of traffic_controller; consumes its enable_n/s/e/w green requests.

---
 rtl/lamp_sequencer.sv | 167 ++++++++++++++++
 tb/tb_lamp_sequencer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/lamp_sequencer.sv
// Lamp driver downstream of the traffic controller: turns single-approach green
// requests into GREEN/AMBER/all-red lamp sequences, with a sticky conflict fault.
module lamp_sequencer #(
   parameter int AMBER_TICKS   = 3,
   parameter int ALL_RED_TICKS = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable_n,
   input  logic       enable_s,
   input  logic       enable_e,
   input  logic       enable_w,
   output logic [2:0] lamp_n,
   output logic [2:0] lamp_s,
   output logic [2:0] lamp_e,
   output logic [2:0] lamp_w,
   output logic       pending,
   output logic       fault
);

   localparam int AW = $clog2(AMBER_TICKS + 1);
   localparam int CW = (ALL_RED_TICKS > 0) ? $clog2(ALL_RED_TICKS + 1) : 1;

   localparam logic [1:0] ST_RED   = 2'd0;
   localparam logic [1:0] ST_GREEN = 2'd1;
   localparam logic [1:0] ST_AMBER = 2'd2;

   localparam logic [2:0] LAMP_RED   = 3'b100;
   localparam logic [2:0] LAMP_AMBER = 3'b010;
   localparam logic [2:0] LAMP_GREEN = 3'b001;

   // Only one approach can ever be out of RED, so one FSM plus an owner index
   // is equivalent to four per-approach FSMs.
   logic [1:0]       r_state, w_state_nxt;
   logic [1:0]       r_owner, w_owner_nxt;
   logic [AW-1:0]    r_amber_cnt, w_amber_nxt;
   logic [CW-1:0]    r_clr_cnt, w_clr_nxt;
   logic             r_fault, w_fault_nxt;
   logic             r_pending, w_pending_nxt;
   logic [3:0][2:0]  r_lamp, w_lamp_nxt;

   logic [3:0]       w_en;
   logic             w_any;
   logic             w_conflict;
   logic             w_clear;
   logic             w_grant;
   logic [1:0]       w_req_idx;

   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

   function automatic logic [1:0] onehot_idx(input logic [3:0] v);
      logic [1:0] idx;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   assign w_en       = {enable_w, enable_e, enable_s, enable_n};
   assign w_any      = |w_en;
   assign w_conflict = multi_hot(w_en);
   assign w_req_idx  = onehot_idx(w_en);
   assign w_clear    = (r_state == ST_RED) && (r_clr_cnt == '0) && !r_fault;
   assign w_grant    = w_clear && w_any && !w_conflict;

   // Next-state, counter and flag computation; fault overrides everything.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_amber_nxt   = r_amber_cnt;
      w_clr_nxt     = r_clr_cnt;
      w_fault_nxt   = r_fault;
      w_pending_nxt = 1'b0;
      if (r_fault || w_conflict) begin
         w_fault_nxt = 1'b1;
         w_state_nxt = ST_RED;
         w_amber_nxt = '0;
         w_clr_nxt   = '0;
      end else begin
         case (r_state)
            ST_RED: begin
               if (w_grant) begin
                  w_state_nxt = ST_GREEN;
                  w_owner_nxt = w_req_idx;
               end else if (tick && (r_clr_cnt != '0)) begin
                  w_clr_nxt = r_clr_cnt - CW'(1);
               end else begin
                  w_clr_nxt = r_clr_cnt;
               end
            end
            ST_GREEN: begin
               if (!w_en[r_owner]) begin
                  w_state_nxt = ST_AMBER;
                  w_amber_nxt = AW'(AMBER_TICKS);
               end else begin
                  w_state_nxt = ST_GREEN;
               end
            end
            ST_AMBER: begin
               if (r_amber_cnt == '0) begin
                  w_state_nxt = ST_RED;
                  w_clr_nxt   = CW'(ALL_RED_TICKS);
               end else if (tick) begin
                  w_amber_nxt = r_amber_cnt - AW'(1);
               end else begin
                  w_amber_nxt = r_amber_cnt;
               end
            end
            default: begin
               w_state_nxt = ST_RED;
               w_amber_nxt = '0;
               w_clr_nxt   = '0;
            end
         endcase
         w_pending_nxt = w_any && !w_grant && !((r_state == ST_GREEN) && w_en[r_owner]);
      end
   end

   // Lamp codes decoded from the next state so the lamp outputs are registered.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         if ((w_state_nxt == ST_GREEN) && (w_owner_nxt == 2'(i))) begin
            w_lamp_nxt[i] = LAMP_GREEN;
         end else if ((w_state_nxt == ST_AMBER) && (w_owner_nxt == 2'(i))) begin
            w_lamp_nxt[i] = LAMP_AMBER;
         end else begin
            w_lamp_nxt[i] = LAMP_RED;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_RED;
         r_owner     <= 2'd0;
         r_amber_cnt <= '0;
         r_clr_cnt   <= '0;
         r_fault     <= 1'b0;
         r_pending   <= 1'b0;
         r_lamp      <= {LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_amber_cnt <= w_amber_nxt;
         r_clr_cnt   <= w_clr_nxt;
         r_fault     <= w_fault_nxt;
         r_pending   <= w_pending_nxt;
         r_lamp      <= w_lamp_nxt;
      end
   end

   assign lamp_n  = r_lamp[0];
   assign lamp_s  = r_lamp[1];
   assign lamp_e  = r_lamp[2];
   assign lamp_w  = r_lamp[3];
   assign pending = r_pending;
   assign fault   = r_fault;

endmodule

// File: tb/tb_lamp_sequencer.sv
// Directed, table-driven bench for lamp_sequencer (AMBER_TICKS=3, ALL_RED_TICKS=1).
module tb_lamp_sequencer;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] A = 3'b010;
   localparam logic [2:0] G = 3'b001;

   typedef struct {
      logic        rst;
      logic        tk;
      logic [3:0]  en;     // {n,s,e,w}
      logic [11:0] lamps;  // {n,s,e,w}
      logic        pend;
      logic        flt;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, tick, enable_n, enable_s, enable_e, enable_w;
   logic [2:0] lamp_n, lamp_s, lamp_e, lamp_w;
   logic       pending, fault;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   lamp_sequencer #(.AMBER_TICKS(3), .ALL_RED_TICKS(1)) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .enable_n(enable_n), .enable_s(enable_s), .enable_e(enable_e), .enable_w(enable_w),
      .lamp_n(lamp_n), .lamp_s(lamp_s), .lamp_e(lamp_e), .lamp_w(lamp_w),
      .pending(pending), .fault(fault)
   );

   task automatic add(input logic r, input logic t, input logic [3:0] en,
                      input logic [11:0] el, input logic ep, input logic ef);
      vec_t v;
      v.rst = r; v.tk = t; v.en = en; v.lamps = el; v.pend = ep; v.flt = ef;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [11:0] el, input logic ep, input logic ef);
      logic [13:0] act;
      logic [13:0] exp;
      act = {lamp_n, lamp_s, lamp_e, lamp_w, pending, fault};
      exp = {el, ep, ef};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got lamps=%b pending=%b fault=%b, expected lamps=%b pending=%b fault=%b",
                  nm, act[13:2], act[1], act[0], el, ep, ef);
      end
   endtask

   // One clock: drive inputs, let the edge sample them, then compare outputs.
   task automatic cyc(input string nm, input logic r, input logic t, input logic [3:0] en,
                      input logic [11:0] el, input logic ep, input logic ef);
      reset = r;
      tick  = t;
      {enable_n, enable_s, enable_e, enable_w} = en;
      @(posedge clk);
      #1;
      check(nm, el, ep, ef);
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0;
      {enable_n, enable_s, enable_e, enable_w} = 4'b0000;

      // Reset, north green, then handover to south with a tick every 4 clocks.
      add(1'b1, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);
      add(1'b0, 1'b0, 4'b1000, {G, R, R, R}, 1'b0, 1'b0);
      add(1'b0, 1'b0, 4'b1000, {G, R, R, R}, 1'b0, 1'b0);
      add(1'b0, 1'b0, 4'b0100, {A, R, R, R}, 1'b1, 1'b0);
      for (int c = 4; c <= 14; c++) begin
         add(1'b0, ((c % 4) == 2) ? 1'b1 : 1'b0, 4'b0100, {A, R, R, R}, 1'b1, 1'b0);
      end
      add(1'b0, 1'b0, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      add(1'b0, 1'b0, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      add(1'b0, 1'b0, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      add(1'b0, 1'b1, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      add(1'b0, 1'b0, 4'b0100, {R, G, R, R}, 1'b0, 1'b0);
      add(1'b0, 1'b0, 4'b0100, {R, G, R, R}, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         cyc($sformatf("handover_vec%0d", i), vecs[i].rst, vecs[i].tk, vecs[i].en,
             vecs[i].lamps, vecs[i].pend, vecs[i].flt);
      end

      // West released in the same cycle as a tick: that tick must not count.
      cyc("w_reset",     1'b1, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("w_green",     1'b0, 1'b0, 4'b0001, {R, R, R, G}, 1'b0, 1'b0);
      cyc("w_drop_tick", 1'b0, 1'b1, 4'b0000, {R, R, R, A}, 1'b0, 1'b0);
      cyc("w_tick1",     1'b0, 1'b1, 4'b0000, {R, R, R, A}, 1'b0, 1'b0);
      cyc("w_n_held",    1'b0, 1'b0, 4'b1000, {R, R, R, A}, 1'b1, 1'b0);
      cyc("w_n_dropped", 1'b0, 1'b0, 4'b0000, {R, R, R, A}, 1'b0, 1'b0);
      cyc("w_tick2",     1'b0, 1'b1, 4'b0000, {R, R, R, A}, 1'b0, 1'b0);
      cyc("w_tick3",     1'b0, 1'b1, 4'b0000, {R, R, R, A}, 1'b0, 1'b0);
      cyc("w_to_red",    1'b0, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);

      // Conflicts latch a sticky fault until reset.
      cyc("f_reset",     1'b1, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("f_ew",        1'b0, 1'b0, 4'b0011, {R, R, R, R}, 1'b0, 1'b1);
      cyc("f_ignore1",   1'b0, 1'b0, 4'b1000, {R, R, R, R}, 1'b0, 1'b1);
      cyc("f_ignore2",   1'b0, 1'b1, 4'b1000, {R, R, R, R}, 1'b0, 1'b1);
      cyc("f_cleared",   1'b1, 1'b0, 4'b1000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("f_n_green",   1'b0, 1'b0, 4'b1000, {G, R, R, R}, 1'b0, 1'b0);
      cyc("f_in_green",  1'b0, 1'b0, 4'b1100, {R, R, R, R}, 1'b0, 1'b1);
      cyc("f_sticky",    1'b0, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b1);

      // South re-asserted during its own amber: amber and clearance still run.
      cyc("s_reset",     1'b1, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("s_green",     1'b0, 1'b0, 4'b0100, {R, G, R, R}, 1'b0, 1'b0);
      cyc("s_amber",     1'b0, 1'b0, 4'b0000, {R, A, R, R}, 1'b0, 1'b0);
      cyc("s_reassert",  1'b0, 1'b0, 4'b0100, {R, A, R, R}, 1'b1, 1'b0);
      cyc("s_tick1",     1'b0, 1'b1, 4'b0100, {R, A, R, R}, 1'b1, 1'b0);
      cyc("s_tick2",     1'b0, 1'b1, 4'b0100, {R, A, R, R}, 1'b1, 1'b0);
      cyc("s_tick3",     1'b0, 1'b1, 4'b0100, {R, A, R, R}, 1'b1, 1'b0);
      cyc("s_allred1",   1'b0, 1'b0, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      cyc("s_allred2",   1'b0, 1'b0, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      cyc("s_clr_tick",  1'b0, 1'b1, 4'b0100, {R, R, R, R}, 1'b1, 1'b0);
      cyc("s_regrant",   1'b0, 1'b0, 4'b0100, {R, G, R, R}, 1'b0, 1'b0);

      // Reset in the middle of north amber clears counters immediately.
      cyc("r_reset",     1'b1, 1'b0, 4'b0000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("r_green",     1'b0, 1'b0, 4'b1000, {G, R, R, R}, 1'b0, 1'b0);
      cyc("r_amber",     1'b0, 1'b0, 4'b0000, {A, R, R, R}, 1'b0, 1'b0);
      cyc("r_amber_tk",  1'b0, 1'b1, 4'b0000, {A, R, R, R}, 1'b0, 1'b0);
      cyc("r_mid_reset", 1'b1, 1'b0, 4'b1000, {R, R, R, R}, 1'b0, 1'b0);
      cyc("r_regrant",   1'b0, 1'b0, 4'b1000, {G, R, R, R}, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
